// File: rtl/simon_iter_core.sv
// Iterative SIMON 2N/MN block cipher: one round per cycle, with on-chip key
// expansion into a T-entry round-key file that is reused across blocks.
module simon_iter_core #(
  parameter int unsigned N = 32,
  parameter int unsigned M = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [N*M-1:0] key,
  output logic           keys_ok,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           mode,
  input  logic [2*N-1:0] in_text,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_text
);

  localparam bit CFG_OK = (N == 16 && M == 4) || (N == 24 && (M == 3 || M == 4)) ||
                          (N == 32 && (M == 3 || M == 4));

  localparam int unsigned T = (N == 16) ? 32 : (N == 24) ? 36 : (M == 3) ? 42 : 44;
  localparam int unsigned CW = $clog2(T + 1);
  localparam int unsigned AW = $clog2(T);

  // Leftmost character of each string is z[0]; indexed as Z[61 - i].
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] ZSEL = (N == 16 || (N == 24 && M == 3)) ? Z0 :
                                 (N == 24) ? Z1 : (M == 3) ? Z2 : Z3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_KEYEXP = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("simon_iter_core: unsupported N/M combination");
    end
  endgenerate

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned s);
    return (v >> s) | (v << (N - s));
  endfunction

  function automatic logic [N-1:0] f_simon(input logic [N-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  logic [1:0]     r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [N-1:0]   r_x, w_x_nxt;
  logic [N-1:0]   r_y, w_y_nxt;
  logic           r_mode, w_mode_nxt;
  logic           r_keys_ok, w_keys_ok_nxt;
  logic           r_out_valid, w_out_valid_nxt;
  logic [2*N-1:0] r_out_text, w_out_text_nxt;
  logic           r_key_ready, r_in_ready;
  logic           w_key_acc, w_kx_we;

  logic [N-1:0]   r_rk [T];

  logic [N-1:0]   w_km1, w_km3, w_kmm, w_tmp, w_kexp;
  logic [5:0]     w_zidx;
  logic           w_zbit;
  logic [AW-1:0]  w_rk_idx;
  logic [N-1:0]   w_rk, w_x_rnd, w_y_rnd;

  // Key schedule step for index i = r_cnt.
  assign w_km1  = r_rk[AW'(r_cnt - CW'(1))];
  assign w_km3  = r_rk[AW'(r_cnt - CW'(3))];
  assign w_kmm  = r_rk[AW'(r_cnt - CW'(M))];
  assign w_zidx = 6'((32'(r_cnt) - M) % 32'd62);
  assign w_zbit = ZSEL[6'd61 - w_zidx];

  always_comb begin
    w_tmp = ror(w_km1, 3);
    if (M == 4) w_tmp = w_tmp ^ w_km3;
    w_kexp = ~w_kmm ^ w_tmp ^ ror(w_tmp, 1) ^ N'(w_zbit) ^ N'(3);
  end

  // Decrypt walks the key file backwards on the swapped state.
  assign w_rk_idx = r_mode ? AW'(r_cnt) : AW'(CW'(T - 1) - r_cnt);
  assign w_rk     = r_rk[w_rk_idx];
  assign w_x_rnd  = r_y ^ f_simon(r_x) ^ w_rk;
  assign w_y_rnd  = r_x;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_mode_nxt      = r_mode;
    w_keys_ok_nxt   = r_keys_ok;
    w_out_valid_nxt = r_out_valid;
    w_out_text_nxt  = r_out_text;
    w_key_acc       = 1'b0;
    w_kx_we         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (key_valid) begin
          w_key_acc     = 1'b1;
          w_keys_ok_nxt = 1'b0;
          w_cnt_nxt     = CW'(M);
          w_state_nxt   = S_KEYEXP;
        end else if (in_valid && r_keys_ok) begin
          w_mode_nxt  = mode;
          w_x_nxt     = mode ? in_text[2*N-1:N] : in_text[N-1:0];
          w_y_nxt     = mode ? in_text[N-1:0]   : in_text[2*N-1:N];
          w_cnt_nxt   = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_KEYEXP: begin
        w_kx_we = 1'b1;
        if (r_cnt == CW'(T - 1)) begin
          w_keys_ok_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RUN: begin
        w_x_nxt = w_x_rnd;
        w_y_nxt = w_y_rnd;
        if (r_cnt == CW'(T - 1)) begin
          w_out_valid_nxt = 1'b1;
          w_out_text_nxt  = r_mode ? {w_x_rnd, w_y_rnd} : {w_y_rnd, w_x_rnd};
          w_cnt_nxt       = '0;
          w_state_nxt     = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_mode      <= 1'b0;
      r_keys_ok   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_text  <= '0;
      r_key_ready <= 1'b1;
      r_in_ready  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_mode      <= w_mode_nxt;
      r_keys_ok   <= w_keys_ok_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_text  <= w_out_text_nxt;
      r_key_ready <= (w_state_nxt == S_IDLE);
      r_in_ready  <= (w_state_nxt == S_IDLE) && w_keys_ok_nxt;
    end
  end

  // Round-key file: master words on load, one derived word per KEYEXP cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_key_acc) begin
        for (int j = 0; j < int'(M); j++) r_rk[AW'(j)] <= key[j*N +: N];
      end else if (w_kx_we) begin
        r_rk[AW'(r_cnt)] <= w_kexp;
      end
    end
  end

  assign key_ready = r_key_ready;
  assign in_ready  = r_in_ready;
  assign keys_ok   = r_keys_ok;
  assign out_valid = r_out_valid;
  assign out_text  = r_out_text;

endmodule

// File: tb/tb_simon_iter_core.sv
// Directed bench for simon_iter_core: published SIMON vectors, handshake,
// backpressure and reset-abort scenarios on 64/96, 32/64 and 64/128 instances.
module tb_simon_iter_core;

  localparam logic [95:0]  K96  = 96'h13121110_0b0a0908_03020100;
  localparam logic [63:0]  PT96 = 64'h6f7220676e696c63;
  localparam logic [63:0]  CT96 = 64'h5ca2e27f111a8fc8;
  localparam logic [63:0]  K64  = 64'h1918_1110_0908_0100;
  localparam logic [31:0]  PT32 = 32'h65656877;
  localparam logic [31:0]  CT32 = 32'hc69be9bb;
  localparam logic [127:0] K128 = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  PT128 = 64'h656b696c20646e75;
  localparam logic [63:0]  CT128 = 64'h44c8fc20b9dfa07a;

  logic clk, rst;

  logic        a_key_valid, a_key_ready, a_keys_ok, a_in_valid, a_in_ready;
  logic        a_mode, a_out_valid, a_out_ready;
  logic [95:0] a_key;
  logic [63:0] a_in_text, a_out_text;

  logic        b_key_valid, b_key_ready, b_keys_ok, b_in_valid, b_in_ready;
  logic        b_mode, b_out_valid, b_out_ready;
  logic [63:0] b_key;
  logic [31:0] b_in_text, b_out_text;

  logic         c_key_valid, c_key_ready, c_keys_ok, c_in_valid, c_in_ready;
  logic         c_mode, c_out_valid, c_out_ready;
  logic [127:0] c_key;
  logic [63:0]  c_in_text, c_out_text;

  int n_pass = 0;
  int n_total = 0;

  simon_iter_core #(.N(32), .M(3)) u_dut (
    .clk(clk), .rst(rst), .key_valid(a_key_valid), .key_ready(a_key_ready), .key(a_key),
    .keys_ok(a_keys_ok), .in_valid(a_in_valid), .in_ready(a_in_ready), .mode(a_mode),
    .in_text(a_in_text), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_text(a_out_text));

  simon_iter_core #(.N(16), .M(4)) u_d16 (
    .clk(clk), .rst(rst), .key_valid(b_key_valid), .key_ready(b_key_ready), .key(b_key),
    .keys_ok(b_keys_ok), .in_valid(b_in_valid), .in_ready(b_in_ready), .mode(b_mode),
    .in_text(b_in_text), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_text(b_out_text));

  simon_iter_core #(.N(32), .M(4)) u_d44 (
    .clk(clk), .rst(rst), .key_valid(c_key_valid), .key_ready(c_key_ready), .key(c_key),
    .keys_ok(c_keys_ok), .in_valid(c_in_valid), .in_ready(c_in_ready), .mode(c_mode),
    .in_text(c_in_text), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_text(c_out_text));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_run(input logic md, input logic [63:0] txt,
                       output logic [63:0] res, output int lat);
    int n = 0;
    a_mode = md;
    a_in_text = txt;
    while (!a_in_ready && n < 200) begin step(); n++; end
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 200) begin step(); lat++; end
    res = a_out_text;
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
  endtask

  task automatic b_run(input logic md, input logic [31:0] txt,
                       output logic [31:0] res, output int lat);
    int n = 0;
    b_mode = md;
    b_in_text = txt;
    while (!b_in_ready && n < 200) begin step(); n++; end
    b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 200) begin step(); lat++; end
    res = b_out_text;
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    a_key_valid = 0; a_in_valid = 0; a_mode = 0; a_out_ready = 0; a_key = '0; a_in_text = '0;
    b_key_valid = 0; b_in_valid = 0; b_mode = 0; b_out_ready = 0; b_key = '0; b_in_text = '0;
    c_key_valid = 0; c_in_valid = 0; c_mode = 0; c_out_ready = 0; c_key = '0; c_in_text = '0;
    rst = 1'b1;
    repeat (3) step();
    n_total++;
    if (a_key_ready !== 1'b1) $display("FAIL reset_key_ready: got %b want 1", a_key_ready);
    else n_pass++;
    n_total++;
    if (a_in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", a_in_ready);
    else n_pass++;
    n_total++;
    if (a_keys_ok !== 1'b0) $display("FAIL reset_keys_ok: got %b want 0", a_keys_ok);
    else n_pass++;
    n_total++;
    if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", a_out_valid);
    else n_pass++;
    n_total++;
    if (a_out_text !== 64'h0) $display("FAIL reset_out_text: got %h want 0", a_out_text);
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_no_key();
    bit seen_rdy = 0;
    bit seen_ov = 0;
    a_mode = 1'b1;
    a_in_text = PT96;
    a_in_valid = 1'b1;
    repeat (20) begin
      step();
      if (a_in_ready) seen_rdy = 1;
      if (a_out_valid) seen_ov = 1;
    end
    n_total++;
    if (seen_rdy !== 1'b0) $display("FAIL nokey_in_ready: got %b want 0", seen_rdy);
    else n_pass++;
    n_total++;
    if (seen_ov !== 1'b0) $display("FAIL nokey_out_valid: got %b want 0", seen_ov);
    else n_pass++;
  endtask

  // in_valid is still high from test_no_key; the key must win.
  task automatic test_key_priority();
    int cyc = 0;
    int lat = 0;
    a_key = K96;
    a_key_valid = 1'b1;
    step();
    a_key_valid = 1'b0;
    n_total++;
    if (a_key_ready !== 1'b0 || a_in_ready !== 1'b0 || a_keys_ok !== 1'b0)
      $display("FAIL prio_keyexp_entry: got kr=%b ir=%b ok=%b want 0 0 0",
               a_key_ready, a_in_ready, a_keys_ok);
    else n_pass++;
    while (!a_keys_ok && cyc < 200) begin step(); cyc++; end
    n_total++;
    if (cyc !== 39) $display("FAIL prio_keyexp_cycles: got %0d want 39", cyc);
    else n_pass++;
    step();
    a_in_valid = 1'b0;
    while (!a_out_valid && lat < 200) begin step(); lat++; end
    n_total++;
    if (lat !== 42) $display("FAIL enc96_latency: got %0d want 42", lat);
    else n_pass++;
    n_total++;
    if (a_out_text !== CT96) $display("FAIL enc96_text: got %h want %h", a_out_text, CT96);
    else n_pass++;
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
  endtask

  task automatic test_decrypt();
    logic [63:0] res;
    int lat;
    a_run(1'b0, CT96, res, lat);
    n_total++;
    if (res !== PT96) $display("FAIL dec96_text: got %h want %h", res, PT96);
    else n_pass++;
    n_total++;
    if (lat !== 42) $display("FAIL dec96_latency: got %0d want 42", lat);
    else n_pass++;
    n_total++;
    if (a_keys_ok !== 1'b1) $display("FAIL dec96_keys_kept: got %b want 1", a_keys_ok);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int n = 0;
    a_mode = 1'b1;
    a_in_text = PT96;
    while (!a_in_ready && n < 200) begin step(); n++; end
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    n = 0;
    while (!a_out_valid && n < 200) begin step(); n++; end
    for (int i = 0; i < 10; i++) begin
      step();
      n_total++;
      if (a_out_valid !== 1'b1 || a_out_text !== CT96 || a_in_ready !== 1'b0)
        $display("FAIL bp_hold_%0d: got ov=%b txt=%h ir=%b want 1 %h 0",
                 i, a_out_valid, a_out_text, a_in_ready, CT96);
      else n_pass++;
    end
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    n_total++;
    if (a_out_valid !== 1'b0 || a_key_ready !== 1'b1 || a_in_ready !== 1'b1)
      $display("FAIL bp_release: got ov=%b kr=%b ir=%b want 0 1 1",
               a_out_valid, a_key_ready, a_in_ready);
    else n_pass++;
  endtask

  task automatic test_s32_64();
    logic [31:0] res;
    int lat;
    int cyc = 0;
    b_key = K64;
    b_key_valid = 1'b1;
    step();
    b_key_valid = 1'b0;
    while (!b_keys_ok && cyc < 200) begin step(); cyc++; end
    n_total++;
    if (cyc !== 28) $display("FAIL s32_keyexp_cycles: got %0d want 28", cyc);
    else n_pass++;
    b_run(1'b1, PT32, res, lat);
    n_total++;
    if (res !== CT32) $display("FAIL enc32_text: got %h want %h", res, CT32);
    else n_pass++;
    n_total++;
    if (lat !== 32) $display("FAIL enc32_latency: got %0d want 32", lat);
    else n_pass++;
    b_run(1'b0, CT32, res, lat);
    n_total++;
    if (res !== PT32) $display("FAIL dec32_text: got %h want %h", res, PT32);
    else n_pass++;
  endtask

  task automatic test_s64_128();
    int cyc = 0;
    int lat = 0;
    c_key = K128;
    c_key_valid = 1'b1;
    step();
    c_key_valid = 1'b0;
    while (!c_keys_ok && cyc < 200) begin step(); cyc++; end
    n_total++;
    if (cyc !== 40) $display("FAIL s128_keyexp_cycles: got %0d want 40", cyc);
    else n_pass++;
    c_mode = 1'b1;
    c_in_text = PT128;
    c_in_valid = 1'b1;
    step();
    c_in_valid = 1'b0;
    while (!c_out_valid && lat < 200) begin step(); lat++; end
    n_total++;
    if (lat !== 44) $display("FAIL enc128_latency: got %0d want 44", lat);
    else n_pass++;
    n_total++;
    if (c_out_text !== CT128) $display("FAIL enc128_text: got %h want %h", c_out_text, CT128);
    else n_pass++;
    c_out_ready = 1'b1;
    step();
    c_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    bit seen_ov = 0;
    bit seen_rdy = 0;
    a_mode = 1'b1;
    a_in_text = PT96;
    while (!a_in_ready && n < 200) begin step(); n++; end
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    step();
    n_total++;
    if (a_keys_ok !== 1'b0 || a_key_ready !== 1'b1 || a_in_ready !== 1'b0 || a_out_valid !== 1'b0)
      $display("FAIL abort_state: got ok=%b kr=%b ir=%b ov=%b want 0 1 0 0",
               a_keys_ok, a_key_ready, a_in_ready, a_out_valid);
    else n_pass++;
    rst = 1'b0;
    a_in_valid = 1'b1;
    repeat (60) begin
      step();
      if (a_out_valid) seen_ov = 1;
      if (a_in_ready) seen_rdy = 1;
    end
    a_in_valid = 1'b0;
    n_total++;
    if (seen_ov !== 1'b0) $display("FAIL abort_out_valid: got %b want 0", seen_ov);
    else n_pass++;
    n_total++;
    if (seen_rdy !== 1'b0) $display("FAIL abort_needs_key: got %b want 0", seen_rdy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_no_key();
    test_key_priority();
    test_decrypt();
    test_backpressure();
    test_s32_64();
    test_s64_128();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/simon_iter_core.md
SIMON_ITER_CORE -- requirements
Module: simon_iter_core

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning word size in bits (legal: 16, 24, 32).
REQ-002 The block SHALL have parameter M, default 3, meaning key words (legal pairs N/M: 16/4, 24/3, 24/4, 32/3, 32/4; any other pair SHALL be rejected at elaboration).
REQ-003 clk  input  1  rising-edge clock; the block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 key_valid  input  1  key load request.
REQ-006 key_ready  output  1  key accepted when key_valid&key_ready at a rising edge.
REQ-007 key  input  N*M  key; key[N-1:0]=k0, key[2N-1:N]=k1, up to k(M-1) at the top.
REQ-008 keys_ok  output  1  full round-key set stored and usable.
REQ-009 in_valid  input  1  block request.
REQ-010 in_ready  output  1  block accepted on in_valid&in_ready.
REQ-011 mode  input  1  1 = encrypt, 0 = decrypt; sampled with the block.
REQ-012 in_text  input  2N  block; upper word = x, lower word = y.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  result consumed on out_valid&out_ready.
REQ-015 out_text  output  2N  result block, same word layout as in_text.

Function
REQ-016 Rounds T SHALL be derived as 16/4:32, 24/3:36, 24/4:36, 32/3:42, 32/4:44, with z sequences z0, z0, z1, z2, z3 respectively (62-bit SIMON constants).
REQ-017 The FSM SHALL have states IDLE, KEYEXP, RUN, DONE.
REQ-018 key_ready SHALL be 1 only in IDLE; in_ready SHALL be 1 only in IDLE with keys_ok=1.
REQ-019 In IDLE, when key_valid and in_valid are both high, the key SHALL take priority and the block SHALL NOT be accepted.
REQ-020 On key acceptance: k0..k(M-1) SHALL be written to a T-entry round-key register file; keys_ok SHALL clear; the state SHALL go to KEYEXP.
REQ-021 KEYEXP SHALL produce one key per cycle for i=M..T-1 (T-M cycles): tmp=ROR3(k[i-1]); if M=4, tmp^=k[i-3]; k[i]=~k[i-M] ^ tmp ^ ROR1(tmp) ^ z[(i-M) mod 62] ^ 3.
REQ-022 After writing k[T-1], keys_ok SHALL set and the state SHALL return to IDLE.
REQ-023 On block acceptance, (x,y) and mode SHALL be registered; RUN SHALL perform exactly one round per cycle for T cycles.
REQ-024 Encrypt round r=0..T-1: x'=y^f(x)^k[r], y'=x, with f(v)=(ROL1 v & ROL8 v)^ROL2 v.
REQ-025 Decrypt round r=0..T-1 uses key k[T-1-r]: y'=x, x'=y^f(x)^k, applied to the swapped state; in_text SHALL be swapped (y,x) on entry and swapped back on exit, so decrypt(encrypt(P))=P.
REQ-026 out_valid SHALL rise exactly T cycles after the acceptance edge; the state SHALL then be DONE.
REQ-027 In DONE, out_text and out_valid SHALL hold stable until out_ready=1; the handshake edge SHALL return the state to IDLE (next block accepted at the following edge at the earliest).
REQ-028 Round-key register file contents SHALL persist across blocks until a new key is accepted or rst is asserted.
REQ-029 All rotations SHALL be modulo N; the round counter SHALL be ceil(log2(T+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-030 While rst=1 at a rising edge: state=IDLE, keys_ok=0, out_valid=0, out_text=0, counter=0; key_ready output SHALL be 1 and in_ready 0 after the reset edge.
REQ-031 rst asserted during KEYEXP or RUN SHALL abort the operation with no output produced; a new key load is required before any block is accepted.

Verification
REQ-032 N=32,M=3: key 0x13121110_0b0a0908_03020100, encrypt 0x6f7220676e696c63 -> out_text 0x5ca2e27f111a8fc8, out_valid 42 cycles after acceptance.
REQ-033 Same key, decrypt 0x5ca2e27f111a8fc8 -> 0x6f7220676e696c63; key reused without reload (keys_ok stays 1).
REQ-034 N=16,M=4: key 0x1918_1110_0908_0100, encrypt 0x65656877 -> 0xc69be9bb; N=32,M=4: key 0x1b1a1918_13121110_0b0a0908_03020100, encrypt 0x656b696c20646e75 -> 0x44c8fc20b9dfa07a.
REQ-035 Backpressure: out_ready held 0 for 10 cycles after out_valid -> out_text unchanged, in_ready=0 throughout; release -> IDLE next cycle.
REQ-036 in_valid before any key -> never accepted; key_valid and in_valid together in IDLE -> key taken, KEYEXP lasts T-M cycles, then block accepted.
REQ-037 rst pulsed mid-RUN (cycle 20) -> out_valid never rises, keys_ok=0, key_ready=1 after the reset edge.
